// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with jump/branch, call/return stack, halt/resume, single-step and sticky fault
module pc_sequencer #(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic              zero_flag,
  input  logic              carry_flag,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              halted,
  output logic              fault,
  output logic [SP_W-1:0]   sp
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [2:0] OP_JMP = 3'b001, OP_BZ = 3'b010, OP_BC = 3'b011,
                         OP_CALL = 3'b100, OP_RET = 3'b101, OP_HALT = 3'b110;
  typedef enum logic [1:0] {S_RUN, S_HALTED, S_FAULT} state_t;
  state_t state;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [ADDR_W-1:0] pc_inc, pc_nxt;
  logic [SP_W-1:0] sp_dec;
  logic advance, full, empty, take, bad;
  always_comb begin
    pc_inc = pc + 1'b1;
    sp_dec = sp - 1'b1;
    full = sp == SP_W'(STACK_DEPTH);
    empty = sp == '0;
    advance = state == S_RUN && (run || step);
    take = op == OP_JMP || op == OP_CALL || (op == OP_BZ && zero_flag) || (op == OP_BC && carry_flag);
    bad = (op == OP_CALL && full) || (op == OP_RET && empty);
    pc_nxt = op == OP_RET ? stack[sp_dec[IDX_W-1:0]] : take ? target : pc_inc;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_RUN;
      pc <= RESET_VECTOR;
      fetch_en <= 1'b0;
      halted <= 1'b0;
      fault <= 1'b0;
      sp <= '0;
    end else begin
      fetch_en <= 1'b0;
      if (state == S_HALTED && resume) begin
        state <= S_RUN;
        halted <= 1'b0;
        pc <= pc_inc;
        fetch_en <= 1'b1;
      end else if (advance) begin
        if (op == OP_HALT) begin
          state <= S_HALTED;
          halted <= 1'b1;
        end else if (bad) begin
          state <= S_FAULT;
          fault <= 1'b1;
        end else begin
          pc <= pc_nxt;
          fetch_en <= 1'b1;
          if (op == OP_CALL) begin
            stack[sp[IDX_W-1:0]] <= pc_inc;
            sp <= sp + 1'b1;
          end
          if (op == OP_RET) sp <= sp_dec;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a queue-based reference model
module tb_pc_sequencer;
  localparam int AW = 8;
  localparam int SD = 4;
  localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, BZ = 3'd2, BC = 3'd3,
                         CALL = 3'd4, RET = 3'd5, HALT = 3'd6;
  logic clk = 1'b0;
  logic rst, run, step, resume, zero_flag, carry_flag;
  logic [2:0] op;
  logic [AW-1:0] target, pc;
  logic fetch_en, halted, fault;
  logic [2:0] sp;
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk[$];
  int m_mode;
  bit m_fe;

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .op(op), .target(target),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .resume(resume),
    .pc(pc), .fetch_en(fetch_en), .halted(halted), .fault(fault), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic go(input logic [AW-1:0] a);
    m_pc = a;
    m_fe = 1'b1;
  endtask

  task automatic cyc(input bit r_n, input bit rn, input bit st, input logic [2:0] o,
                     input logic [AW-1:0] tg, input bit z, input bit c, input bit rs);
    rst = r_n; run = rn; step = st; op = o; target = tg;
    zero_flag = z; carry_flag = c; resume = rs;
    m_fe = 1'b0;
    if (!r_n) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (rs) begin
        go(m_pc + 8'd1);
        m_mode = 0;
      end
    end else if (m_mode == 0 && (rn || st)) begin
      case (o)
        JMP: go(tg);
        BZ: go(z ? tg : m_pc + 8'd1);
        BC: go(c ? tg : m_pc + 8'd1);
        CALL: if (m_stk.size() == SD) m_mode = 2;
              else begin m_stk.push_back(m_pc + 8'd1); go(tg); end
        RET: if (m_stk.size() == 0) m_mode = 2;
             else go(m_stk.pop_back());
        HALT: m_mode = 1;
        default: go(m_pc + 8'd1);
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input logic [2:0] o, input logic [AW-1:0] tg);
    cyc(1, 1, 0, o, tg, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(0, 1, 1, JMP, 8'h55, 1, 1, 1);
  endtask

  task automatic test_reset();
    cyc(1, 1, 0, JMP, 8'h33, 0, 0, 0);
    do_reset();
    checks++;
    if ({pc, fetch_en, halted, fault, sp} !== {8'h00, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset: pc=%h fe=%b h=%b f=%b sp=%0d required pc=00 fe=0 h=0 f=0 sp=0",
               pc, fetch_en, halted, fault, sp);
    end
  endtask

  task automatic test_next_wrap();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      adv(NEXT, 8'hAA);
      checks++;
      if (pc !== 8'(i) || fetch_en !== 1'b1) begin
        errors++;
        $display("FAIL next_%0d: pc=%h fe=%b required pc=%h fe=1", i, pc, fetch_en, 8'(i));
      end
    end
    adv(JMP, 8'hFF);
    adv(NEXT, 8'h12);
    checks++;
    if (pc !== 8'h00 || fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL wrap: pc=%h fe=%b required pc=00 fe=1", pc, fetch_en);
    end
    adv(JMP, 8'hFF);
    adv(CALL, 8'h30);
    adv(RET, 8'h77);
    checks++;
    if (pc !== 8'h00 || sp !== 3'd0) begin
      errors++;
      $display("FAIL call_wrap: pc=%h sp=%0d required pc=00 sp=0", pc, sp);
    end
  endtask

  task automatic test_branch();
    logic [AW-1:0] exp;
    for (int k = 0; k < 4; k++) begin
      adv(JMP, 8'h05);
      cyc(1, 1, 0, (k < 2) ? BZ : BC, 8'h40, k == 1, k == 3, 0);
      exp = k[0] ? 8'h40 : 8'h06;
      checks++;
      if (pc !== exp || fetch_en !== 1'b1) begin
        errors++;
        $display("FAIL branch_%0d: pc=%h fe=%b required pc=%h fe=1", k, pc, fetch_en, exp);
      end
    end
    adv(JMP, 8'h05);
    cyc(1, 1, 0, BZ, 8'h40, 0, 1, 0);
    checks++;
    if (pc !== 8'h06) begin
      errors++;
      $display("FAIL bz_ignores_carry: pc=%h required 06", pc);
    end
  endtask

  task automatic test_call_ret();
    logic [AW-1:0] exp_pc [4] = '{8'h10, 8'h20, 8'h11, 8'h03};
    logic [2:0] exp_sp [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    do_reset();
    adv(JMP, 8'h02);
    for (int i = 0; i < 4; i++) begin
      adv(i < 2 ? CALL : RET, i == 0 ? 8'h10 : 8'h20);
      checks++;
      if (pc !== exp_pc[i] || sp !== exp_sp[i] || fetch_en !== 1'b1) begin
        errors++;
        $display("FAIL call_ret_%0d: pc=%h sp=%0d fe=%b required pc=%h sp=%0d fe=1",
                 i, pc, sp, fetch_en, exp_pc[i], exp_sp[i]);
      end
    end
  endtask

  task automatic test_fault();
    logic [AW-1:0] frozen;
    do_reset();
    for (int i = 0; i < 4; i++) adv(CALL, 8'(8'h40 + 8'(i * 8)));
    frozen = pc;
    adv(CALL, 8'hE0);
    checks++;
    if (fault !== 1'b1 || pc !== frozen || sp !== 3'd4 || fetch_en !== 1'b0) begin
      errors++;
      $display("FAIL overflow: f=%b pc=%h sp=%0d fe=%b required f=1 pc=%h sp=4 fe=0",
               fault, pc, sp, fetch_en, frozen);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, i[0], 1, i[1] ? RET : JMP, 8'h99, 1, 1, 1);
      checks++;
      if (fault !== 1'b1 || pc !== frozen || sp !== 3'd4 || fetch_en !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL fault_frozen_%0d: f=%b pc=%h sp=%0d fe=%b h=%b required f=1 pc=%h sp=4 fe=0 h=0",
                 i, fault, pc, sp, fetch_en, halted, frozen);
      end
    end
    do_reset();
    checks++;
    if (fault !== 1'b0 || pc !== 8'h00 || sp !== 3'd0) begin
      errors++;
      $display("FAIL fault_reset: f=%b pc=%h sp=%0d required f=0 pc=00 sp=0", fault, pc, sp);
    end
    adv(JMP, 8'h21);
    adv(RET, 8'h00);
    checks++;
    if (fault !== 1'b1 || pc !== 8'h21 || fetch_en !== 1'b0) begin
      errors++;
      $display("FAIL underflow: f=%b pc=%h fe=%b required f=1 pc=21 fe=0", fault, pc, fetch_en);
    end
    do_reset();
  endtask

  task automatic test_halt();
    adv(JMP, 8'h07);
    adv(HALT, 8'h44);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (halted !== 1'b1 || pc !== 8'h07 || fetch_en !== 1'b0) begin
        errors++;
        $display("FAIL halt_%0d: h=%b pc=%h fe=%b required h=1 pc=07 fe=0", i, halted, pc, fetch_en);
      end
      cyc(1, 1, i[0], JMP, 8'h66, 0, 0, 0);
    end
    cyc(1, 0, 0, NEXT, 8'h00, 0, 0, 1);
    checks++;
    if (halted !== 1'b0 || pc !== 8'h08 || fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL resume: h=%b pc=%h fe=%b required h=0 pc=08 fe=1", halted, pc, fetch_en);
    end
    cyc(1, 0, 0, NEXT, 8'h00, 0, 0, 1);
    checks++;
    if (pc !== 8'h08 || fetch_en !== 1'b0) begin
      errors++;
      $display("FAIL resume_in_run: pc=%h fe=%b required pc=08 fe=0", pc, fetch_en);
    end
    adv(HALT, 8'h00);
    do_reset();
    checks++;
    if (halted !== 1'b0 || pc !== 8'h00) begin
      errors++;
      $display("FAIL halt_reset: h=%b pc=%h required h=0 pc=00", halted, pc);
    end
  endtask

  task automatic test_step();
    adv(JMP, 8'h20);
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 0, 1, NEXT, 8'h00, 0, 0, 0);
      checks++;
      if (pc !== 8'(8'h20 + 8'(i)) || fetch_en !== 1'b1) begin
        errors++;
        $display("FAIL step_%0d: pc=%h fe=%b required pc=%h fe=1", i, pc, fetch_en, 8'(8'h20 + 8'(i)));
      end
      for (int j = 0; j < 2; j++) begin
        cyc(1, 0, 0, JMP, 8'hCC, 0, 0, 0);
        checks++;
        if (pc !== 8'(8'h20 + 8'(i)) || fetch_en !== 1'b0) begin
          errors++;
          $display("FAIL step_idle_%0d_%0d: pc=%h fe=%b required pc=%h fe=0",
                   i, j, pc, fetch_en, 8'(8'h20 + 8'(i)));
        end
      end
    end
    cyc(1, 1, 1, NEXT, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, NEXT, 8'h00, 0, 0, 0);
    checks++;
    if (pc !== 8'h24) begin
      errors++;
      $display("FAIL run_and_step: pc=%h required 24", pc);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      o = 3'($urandom_range(0, 7));
      if (o == HALT && $urandom_range(0, 2) != 0) o = NEXT;
      cyc($urandom_range(0, 40) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, o,
          8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0);
      checks++;
      if ({pc, fetch_en, halted, fault, sp} !==
          {m_pc, m_fe, m_mode == 1, m_mode == 2, 3'(m_stk.size())}) begin
        errors++;
        $display("FAIL random_%0d: pc=%h fe=%b h=%b f=%b sp=%0d required pc=%h fe=%b h=%b f=%b sp=%0d",
                 i, pc, fetch_en, halted, fault, sp, m_pc, m_fe, m_mode == 1, m_mode == 2, m_stk.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_next_wrap();
    test_branch();
    test_call_ret();
    test_fault();
    test_halt();
    test_step();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-sequencing block that replaces the plain program counter in the CPU top level. It drives the instruction ROM address and supports sequential fetch, unconditional jump, branch on the ALU zero/carry flags, and subroutine call/return through an internal return-address stack. It also provides halt/resume, a single-step debug mode, and sticky fault reporting. The instruction decoder supplies the operation and target each cycle; the datapath supplies the flags.

## Interface
Parameters:
- ADDR_W, 8, PC/ROM address width
- STACK_DEPTH, 4, return-stack entries; power of two, ≥2
- RESET_VECTOR, 0, PC value after reset; ADDR_W bits

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- run  in  1  level; free-running advance enable
- step  in  1  one-cycle pulse; single advance while run=0
- op  in  3  sequencing op: 000 NEXT, 001 JMP, 010 BZ, 011 BC, 100 CALL, 101 RET, 110 HALT, 111 reserved (behaves as NEXT)
- target  in  ADDR_W  jump/branch/call destination
- zero_flag  in  1  ALU zero flag, sampled with op
- carry_flag  in  1  ALU carry flag, sampled with op
- resume  in  1  one-cycle pulse; leaves HALTED
- pc  out  ADDR_W  current instruction address (registered)
- fetch_en  out  1  high for exactly the one cycle in which pc first holds a new value
- halted  out  1  high while in HALTED
- fault  out  1  sticky stack overflow/underflow indicator
- sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries

## Operation
- States: RUN, HALTED, FAULT. Reset enters RUN.
- Advance condition: state=RUN and (run=1 or step=1). run and step both high gives a single advance, not two. step and run are ignored in HALTED and FAULT.
- On advance, op is evaluated against the current pc:
  - NEXT/reserved: pc ← pc+1.
  - JMP: pc ← target.
  - BZ: pc ← target if zero_flag, else pc+1.
  - BC: pc ← target if carry_flag, else pc+1.
  - CALL: if sp<STACK_DEPTH, push pc+1, sp+1, pc ← target. If sp=STACK_DEPTH, go to FAULT; pc and stack are unchanged.
  - RET: if sp>0, pc ← top entry, sp−1. If sp=0, go to FAULT; pc is unchanged.
  - HALT: pc is unchanged; go to HALTED.
- Without an advance, pc, stack and sp hold.
- Arithmetic: pc+1 is modulo 2^ADDR_W; 2^ADDR_W−1 wraps to 0. A CALL at that address pushes 0.
- HALTED: halted=1. A resume pulse sets pc ← pc+1 and returns to RUN. resume in RUN or FAULT is ignored.
- FAULT: fault=1 and pc is frozen. The only exit is reset. Stack contents are retained but unused.
- A return to the same pc (e.g. JMP to self) still counts as a new value for fetch_en purposes.
- Reset with rst=0 at any clock edge, including mid-halt or mid-fault, overrides all inputs.

## Timing
- Reset values: pc=RESET_VECTOR, fetch_en=0, halted=0, fault=0, sp=0; state RUN.
- Latency: op, target and flags are sampled at edge N when the advance condition holds. The new pc is visible after edge N, and fetch_en=1 during that following cycle.
- fetch_en is 0 in every cycle without a fresh update, including the HALT and fault transitions.
- halted and fault assert in the cycle after the edge that sampled the HALT op or the faulting op.
- Resume: pulse sampled at edge N; after edge N, halted=0, pc=old+1 and fetch_en=1.
- All outputs are registered; there is no combinational input-to-output path.
- Sustained run=1 with NEXT gives one pc increment and one fetch_en per cycle.

## Test plan
- Reset then run=1, op=NEXT for 4 cycles: pc goes 0→1→2→3→4 and fetch_en=1 each cycle. With ADDR_W=8 and pc=8'hFF plus NEXT, the next pc is 8'h00.
- BZ target=8'h40 from pc=5: with zero_flag=0, pc=6. Repeat from pc=5 with zero_flag=1: pc=8'h40. Same check for BC with carry_flag.
- Nested CALL 8'h10 from pc=2, CALL 8'h20 from 8'h10, then RET, RET: pc goes 8'h10 (sp=1), 8'h20 (sp=2), 8'h11 (sp=1), 8'h03 (sp=0).
- Five CALLs with STACK_DEPTH=4: the 5th sets fault=1 with pc and sp=4 frozen; later run, step and resume have no effect. Separately, RET at sp=0 sets fault=1. rst=0 clears fault and sets pc=RESET_VECTOR.
- HALT at pc=7: halted=1, pc=7, fetch_en=0 for 10 cycles with run=1. A resume pulse gives pc=8, halted=0 and fetch_en=1 for one cycle.
- run=0 with three step pulses spaced 3 cycles apart gives exactly three increments. step and run both high for 1 cycle gives one increment. rst=0 asserted mid-halt gives pc=RESET_VECTOR and halted=0 on the next edge.
